// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, register index and writeback source select.
package cpu_types_pkg;

    localparam int unsigned WORD_W_DEF = 32;

    typedef logic [WORD_W_DEF-1:0] word_t;
    typedef logic [4:0]            regbits_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_LINK = 2'd2,
        WB_LUI  = 2'd3
    } wbsrc_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: instruction fields and stage control from MEM, register-file write port back out.
interface mem_wb_stage_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) ();

    logic              wb_en;
    logic              wb_flush;
    logic              mem_valid;
    logic              mem_regwen;
    regbits_t          mem_wsel;
    wbsrc_t            mem_wbsrc;
    logic [WORD_W-1:0] mem_aluout;
    logic [WORD_W-1:0] mem_dload;
    logic [WORD_W-1:0] mem_npc;
    logic [15:0]       mem_imm16;
    logic              mem_halt;

    logic              WEN;
    regbits_t          wsel;
    logic [WORD_W-1:0] wdat;
    logic              fwd_valid;

    modport master (
        output wb_en, wb_flush, mem_valid, mem_regwen, mem_wsel, mem_wbsrc,
               mem_aluout, mem_dload, mem_npc, mem_imm16, mem_halt,
        input  WEN, wsel, wdat, fwd_valid
    );

    modport slave (
        input  wb_en, wb_flush, mem_valid, mem_regwen, mem_wsel, mem_wbsrc,
               mem_aluout, mem_dload, mem_npc, mem_imm16, mem_halt,
        output WEN, wsel, wdat, fwd_valid
    );

endinterface

// File: rtl/mem_wb_stage_wb_data_mux.sv
// Writeback data select: picks ALU result, load data, link address or LUI immediate.
module wb_data_mux
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  wbsrc_t            wbsrc,
    input  logic [WORD_W-1:0] aluout,
    input  logic [WORD_W-1:0] dload,
    input  logic [WORD_W-1:0] npc,
    input  logic [15:0]       imm16,
    output logic [WORD_W-1:0] wdat
);

    always_comb begin
        wdat = '0;
        case (wbsrc)
            WB_ALU:  wdat = aluout;
            WB_LOAD: wdat = dload;
            WB_LINK: wdat = npc;
            WB_LUI:  wdat = {imm16, {(WORD_W-16){1'b0}}};
            default: wdat = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register driving the register-file write port, with a sticky halt
// flag and a retired-instruction counter.
module mem_wb_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                CLK,
    input  logic                RST,
    mem_wb_stage_if.slave       bus,
    output logic                halt,
    output logic [RETIRE_W-1:0] retired
);

    logic              s_valid;
    logic              s_regwen;
    regbits_t          s_wsel;
    wbsrc_t            s_wbsrc;
    logic [WORD_W-1:0] s_aluout;
    logic [WORD_W-1:0] s_dload;
    logic [WORD_W-1:0] s_npc;
    logic [15:0]       s_imm16;
    logic              s_halt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_valid  <= 1'b0;
            s_regwen <= 1'b0;
            s_wsel   <= '0;
            s_wbsrc  <= WB_ALU;
            s_aluout <= '0;
            s_dload  <= '0;
            s_npc    <= '0;
            s_imm16  <= '0;
            s_halt   <= 1'b0;
            halt     <= 1'b0;
            retired  <= '0;
        end else if (!halt) begin
            // Flush only kills the control bits; data fields are left as they were.
            if (bus.wb_flush) begin
                s_valid  <= 1'b0;
                s_regwen <= 1'b0;
                s_halt   <= 1'b0;
            end else if (bus.wb_en) begin
                s_valid  <= bus.mem_valid;
                s_regwen <= bus.mem_regwen;
                s_wsel   <= bus.mem_wsel;
                s_wbsrc  <= bus.mem_wbsrc;
                s_aluout <= bus.mem_aluout;
                s_dload  <= bus.mem_dload;
                s_npc    <= bus.mem_npc;
                s_imm16  <= bus.mem_imm16;
                s_halt   <= bus.mem_halt;
            end
            if (s_valid && s_halt)
                halt <= 1'b1;
            if (s_valid && (bus.wb_en || bus.wb_flush))
                retired <= retired + RETIRE_W'(1);
        end
    end

    wb_data_mux #(.WORD_W(WORD_W)) u_wb_data_mux (
        .wbsrc  (s_wbsrc),
        .aluout (s_aluout),
        .dload  (s_dload),
        .npc    (s_npc),
        .imm16  (s_imm16),
        .wdat   (bus.wdat)
    );

    assign bus.WEN       = s_valid && s_regwen && (s_wsel != '0) && !s_halt && !halt;
    assign bus.wsel      = s_wsel;
    assign bus.fwd_valid = bus.WEN;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against an instruction-level reference model.
module tb_mem_wb_stage;
    import cpu_types_pkg::*;

    localparam int unsigned RW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          halt;
    logic [RW-1:0] retired;

    mem_wb_stage_if #(.WORD_W(32)) bus ();

    mem_wb_stage #(.WORD_W(32), .RETIRE_W(RW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .halt    (halt),
        .retired (retired)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          valid;
        bit          regwen;
        bit          is_halt;
        logic [4:0]  wsel;
        logic [31:0] value;
    } instr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    instr_t      slot;
    instr_t      incoming;
    bit          m_halted;
    int unsigned m_ret;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_value(input int unsigned src, input logic [31:0] alu,
                                              input logic [31:0] ld, input logic [31:0] npc,
                                              input logic [15:0] imm);
        case (src)
            0:       return alu;
            1:       return ld;
            2:       return npc;
            default: return {imm, 16'h0000};
        endcase
    endfunction

    task automatic model_reset();
        slot     = '{valid: 0, regwen: 0, is_halt: 0, wsel: 5'd0, value: 32'd0};
        m_halted = 0;
        m_ret    = 0;
    endtask

    task automatic apply(input bit v, input bit rw, input logic [4:0] ws, input int unsigned src,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] npc,
                         input logic [15:0] imm, input bit h, input bit en, input bit fl);
        bus.mem_valid  = v;
        bus.mem_regwen = rw;
        bus.mem_wsel   = ws;
        bus.mem_wbsrc  = wbsrc_t'(2'(src));
        bus.mem_aluout = alu;
        bus.mem_dload  = ld;
        bus.mem_npc    = npc;
        bus.mem_imm16  = imm;
        bus.mem_halt   = h;
        bus.wb_en      = en;
        bus.wb_flush   = fl;
        incoming = '{valid: v, regwen: rw, is_halt: h, wsel: ws,
                     value: ref_value(src, alu, ld, npc, imm)};
    endtask

    task automatic apply_random(input bit en, input bit fl);
        apply(($urandom % 5) != 0, ($urandom % 4) != 0, 5'($urandom), $urandom % 4,
              $urandom, $urandom, $urandom, 16'($urandom), ($urandom % 30) == 0, en, fl);
    endtask

    task automatic check_outputs(input string tag);
        bit exp_wen;
        exp_wen = slot.valid && slot.regwen && (slot.wsel != 0) && !slot.is_halt && !m_halted;
        check_eq({tag, ".wen"}, 32'(bus.WEN), 32'(exp_wen));
        check_eq({tag, ".fwd"}, 32'(bus.fwd_valid), 32'(exp_wen));
        check_eq({tag, ".halt"}, 32'(halt), 32'(m_halted));
        check_eq({tag, ".retired"}, 32'(retired), m_ret % (1 << RW));
        if (exp_wen) begin
            check_eq({tag, ".wsel"}, 32'(bus.wsel), 32'(slot.wsel));
            check_eq({tag, ".wdat"}, bus.wdat, slot.value);
        end
    endtask

    task automatic step(input string tag);
        bit leaving;
        bit stop;
        @(posedge CLK);
        if (!RST && !m_halted) begin
            leaving = slot.valid && (bus.wb_en || bus.wb_flush);
            stop    = slot.valid && slot.is_halt;
            if (bus.wb_flush)
                slot.valid = 0;
            else if (bus.wb_en)
                slot = incoming;
            if (leaving) m_ret++;
            if (stop) m_halted = 1;
        end
        #1;
        check_outputs(tag);
    endtask

    // Asserts reset between clock edges, checks the immediate clear, holds 3 cycles, releases.
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        check_eq({tag, ".wsel0"}, 32'(bus.wsel), 32'd0);
        check_eq({tag, ".wdat0"}, bus.wdat, 32'd0);
        repeat (3) step({tag, ".hold"});
        #3;
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        apply(0, 0, 5'd0, 0, 32'd0, 32'd0, 32'd0, 16'd0, 0, 0, 0);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        check_outputs("t1.por");
        RST = 1'b0;

        apply(1, 1, 5'd3, 0, 32'h5555_AAAA, 32'd0, 32'd0, 16'd0, 0, 1, 0);
        step("t1.pre");
        async_reset("t1.rst");

        apply(1, 1, 5'd8, 0, 32'h0000_1234, $urandom, $urandom, 16'($urandom), 0, 1, 0);
        step("t2.alu");
        apply(1, 1, 5'd9, 3, $urandom, $urandom, $urandom, 16'hBEEF, 0, 1, 0);
        step("t2.lui");
        check_eq("t2.lui_val", bus.wdat, 32'hBEEF_0000);
        apply(1, 1, 5'd31, 2, $urandom, $urandom, 32'h0040_0008, 16'($urandom), 0, 1, 0);
        step("t2.link");
        apply(1, 1, 5'd1, 1, $urandom, 32'hDEAD_BEEF, $urandom, 16'($urandom), 0, 1, 0);
        step("t2.load");
        apply(0, 0, 5'd0, 0, 32'd0, 32'd0, 32'd0, 16'd0, 0, 1, 0);
        step("t2.drain");
        check_eq("t2.retired4", 32'(retired), 32'd4);

        apply(1, 1, 5'd12, 0, 32'hCAFE_0001, 32'd0, 32'd0, 16'd0, 0, 1, 0);
        step("t3.cap");
        repeat (3) begin
            apply_random(0, 0);
            step("t3.stall");
        end
        apply_random(1, 1);
        step("t3.flush");
        apply(1, 1, 5'd7, 1, 32'd0, 32'h0BAD_F00D, 32'd0, 16'd0, 0, 1, 0);
        step("t3.cap2");
        apply_random(0, 0);
        step("t3.stall2");
        async_reset("t3.rst");
        apply(1, 1, 5'd2, 0, 32'h1111_2222, 32'd0, 32'd0, 16'd0, 0, 1, 0);
        step("t3.after");

        apply(1, 1, 5'd0, 0, 32'hFFFF_FFFF, 32'd0, 32'd0, 16'd0, 0, 1, 0);
        step("t4.zero");
        apply(0, 0, 5'd0, 0, 32'd0, 32'd0, 32'd0, 16'd0, 0, 1, 0);
        step("t4.ret");

        apply(1, 1, 5'd5, 0, 32'h7777_7777, 32'd0, 32'd0, 16'd0, 1, 1, 0);
        step("t5.cap");
        apply(1, 1, 5'd6, 0, 32'h8888_8888, 32'd0, 32'd0, 16'd0, 0, 1, 0);
        step("t5.halt");
        repeat (5) begin
            apply(1, 1, 5'($urandom_range(1, 31)), 0, $urandom, 32'd0, 32'd0, 16'd0, 0, 1, 0);
            step("t5.frozen");
        end
        check_eq("t5.sticky", 32'(halt), 32'd1);
        async_reset("t5.rst");

        repeat (18) begin
            apply(1, 1, 5'($urandom), $urandom % 4, $urandom, $urandom, $urandom,
                  16'($urandom), 0, 1, 0);
            step("t6.ret");
        end
        check_eq("t6.wrap", 32'(retired), 32'd1);

        repeat (400) begin
            if (m_halted && ($urandom % 4) == 0) begin
                async_reset("rnd.rst");
            end else begin
                apply_random(($urandom % 10) < 7, ($urandom % 10) == 0);
                step("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
